// File: rtl/mips32_pkg.sv
// Shared types for the MIPS32 hazard scoreboard: register index, in-flight
// entry record and the hard-wired zero register.
package mips32_pkg;

  localparam int ARCH_REGS = 32;
  localparam int REG_W     = $clog2(ARCH_REGS);

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     v;
    reg_idx_t rd;
  } sb_entry_t;

  localparam reg_idx_t R0 = {REG_W{1'b0}};

endpackage

// File: rtl/mips32_scoreboard_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Count events, hold at all-ones, clear on request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {W{1'b0}};
    end else if (clr) begin
      q_r <= {W{1'b0}};
    end else if (inc && (q_r != {W{1'b1}})) begin
      q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mips32_scoreboard.sv
// RAW-hazard interlock beside ID: tracks destinations of in-flight instructions
// in a shift line and stalls issue while a used source is still pending.
module mips32_scoreboard
  import mips32_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int PIPE_DEPTH   = 3,
  parameter int FLUSH_STAGES = 1,
  parameter int CNT_W        = 32,
  localparam int IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [IDX_W-1:0]    id_rs,
  input  logic [IDX_W-1:0]    id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [IDX_W-1:0]    id_rd,
  input  logic                id_writes,
  input  logic                flush,
  input  logic                cnt_clr,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_cycles
);

  sb_entry_t [PIPE_DEPTH-1:0] line_r;
  sb_entry_t [PIPE_DEPTH-1:0] line_next_s;
  logic [NUM_REGS-1:0]        busy_r;
  logic [NUM_REGS-1:0]        busy_next_s;
  reg_idx_t                   rs_s;
  reg_idx_t                   rt_s;
  reg_idx_t                   rd_s;
  logic                       rs_hit_s;
  logic                       rt_hit_s;
  logic                       stall_s;
  logic                       accept_s;

  assign rs_s = reg_idx_t'(id_rs);
  assign rt_s = reg_idx_t'(id_rt);
  assign rd_s = reg_idx_t'(id_rd);

  // Compare used, non-zero sources against every valid in-flight entry.
  always_comb begin
    rs_hit_s = 1'b0;
    rt_hit_s = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      rs_hit_s = rs_hit_s | (line_r[k].v & id_uses_rs & (rs_s != R0) & (line_r[k].rd == rs_s));
      rt_hit_s = rt_hit_s | (line_r[k].v & id_uses_rt & (rt_s != R0) & (line_r[k].rd == rt_s));
    end
    stall_s  = id_valid & (rs_hit_s | rt_hit_s);
    accept_s = id_valid & ~stall_s & ~flush;
  end

  // Next shift-line contents; a flush kills the youngest entries as they advance.
  always_comb begin
    line_next_s       = line_r;
    line_next_s[0].v  = accept_s & id_writes & (rd_s != R0);
    line_next_s[0].rd = rd_s;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      line_next_s[k].rd = line_r[k-1].rd;
      line_next_s[k].v  = line_r[k-1].v & ~(flush & (k <= FLUSH_STAGES));
    end
  end

  // Pending-write mask derived from the next line so the registered view matches state.
  always_comb begin
    busy_next_s = {NUM_REGS{1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        busy_next_s[r] = busy_next_s[r] | (line_next_s[k].v & (line_next_s[k].rd == reg_idx_t'(r)));
      end
    end
  end

  // Advance the hazard line and its busy view every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_r <= '0;
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      line_r <= line_next_s;
      busy_r <= busy_next_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_s),
    .clr (cnt_clr),
    .q   (stall_cycles)
  );

  assign stall     = stall_s;
  assign busy_mask = busy_r;

endmodule

// File: tb/tb_mips32_scoreboard.sv
// Directed bench for mips32_scoreboard (PIPE_DEPTH=3, FLUSH_STAGES=1, CNT_W=4).
module tb_mips32_scoreboard;

  localparam int PD = 3;
  localparam int FS = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [4:0]    id_rs = 5'd0;
  logic [4:0]    id_rt = 5'd0;
  logic          id_uses_rs = 1'b0;
  logic          id_uses_rt = 1'b0;
  logic [4:0]    id_rd = 5'd0;
  logic          id_writes = 1'b0;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          stall;
  logic [31:0]   busy_mask;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  mips32_scoreboard #(
    .NUM_REGS(32), .PIPE_DEPTH(PD), .FLUSH_STAGES(FS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_writes(id_writes), .flush(flush), .cnt_clr(cnt_clr), .stall(stall),
    .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] rd,
                     input logic wr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rd = rd; id_writes = wr; flush = fl;
    #1;
  endtask

  task automatic idle();
    put(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    idle();
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_busy", busy_mask, 32'h0);
    chk("reset_cnt", {28'd0, stall_cycles}, 32'd0);

    // Independent producers and an R0/unwritten-source consumer
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
    chk("indep_r1_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("indep_busy1", busy_mask, 32'h2);
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    chk("indep_r2_stall", {31'd0, stall}, 32'd0);
    tick();
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    chk("indep_r3_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("indep_busy3", busy_mask, 32'hE);
    put(1'b1, 5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    chk("indep_r0_r7_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("indep_r0_never_busy", busy_mask, 32'hC);
    idle();
    tick(); tick(); tick();
    chk("drained_busy", busy_mask, 32'h0);

    // Dependent chain: ADDI R1,R0,10 then ADD R4,R1,R2
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    chk("dep_stall_c1", {31'd0, stall}, 32'd1);
    chk("dep_busy_c1", busy_mask, 32'h2);
    tick();
    chk("dep_stall_c2", {31'd0, stall}, 32'd1);
    chk("dep_busy_c2", busy_mask, 32'h2);
    tick();
    chk("dep_stall_c3", {31'd0, stall}, 32'd1);
    tick();
    chk("dep_stall_released", {31'd0, stall}, 32'd0);
    chk("dep_busy_released", busy_mask, 32'h0);
    chk("dep_cnt", {28'd0, stall_cycles}, 32'd3);
    tick();
    chk("dep_add_accepted", busy_mask, 32'h10);

    // Mid-run reset with three valid entries
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    chk("pre_reset_busy", busy_mask, 32'hE);
    put(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_reset_stall", {31'd0, stall}, 32'd0);
    chk("mid_reset_busy", busy_mask, 32'h0);
    chk("mid_reset_cnt", {28'd0, stall_cycles}, 32'd0);
    idle();
    tick();
    rst = 1'b0;

    // Flush: ADDI R5, then ADD R6,R5,R0 with flush on the next edge
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    chk("flush_pre_busy", busy_mask, 32'h20);
    put(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1);
    chk("flush_match_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("flush_busy", busy_mask, 32'h0);
    chk("flush_cnt", {28'd0, stall_cycles}, 32'd1);

    // Unused source: SW-style rt pending but not read
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd9, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("unused_rt_no_stall", {31'd0, stall}, 32'd0);
    put(1'b1, 5'd9, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("used_rt_stall", {31'd0, stall}, 32'd1);
    idle();
    tick(); tick(); tick();

    // Back-to-back producers to R1: consumer waits for the younger one
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    chk("b2b_stall_c1", {31'd0, stall}, 32'd1);
    tick(); tick();
    chk("b2b_stall_after_older_retires", {31'd0, stall}, 32'd1);
    chk("b2b_busy_younger", busy_mask, 32'h2);
    tick();
    chk("b2b_released", {31'd0, stall}, 32'd0);
    chk("b2b_cnt", {28'd0, stall_cycles}, 32'd4);
    idle();
    tick(); tick(); tick(); tick();

    // Saturation: ADD R1,R1,R1 held continuously gives 3 stalls per 4 cycles
    put(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
    chk("sat_first_no_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 29; i++) tick();
    chk("sat_stall_active", {31'd0, stall}, 32'd1);
    chk("sat_cnt_sticks", {28'd0, stall_cycles}, 32'd15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sat_clr_while_stalled", {28'd0, stall_cycles}, 32'd0);
    chk("sat_still_stalled", {31'd0, stall}, 32'd1);
    tick();
    chk("sat_count_resumes", {28'd0, stall_cycles}, 32'd1);
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
